// File: rtl/system_widths_pkg.sv
// rtl/system_widths_pkg.sv - shared widths, FSM state type and helpers for cache_dm
package system_widths_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_LINES = 16;
    localparam int CNT_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP     = 2'd1,
        ST_MEM_REQ  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } cache_state_e;

    // Saturating increment: statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cache_dm_array.sv
// rtl/cache_dm_array.sv - valid/tag/data storage, one read port, one write port, bulk valid clear
module cache_dm_array
    import system_widths_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = DEF_ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES];
    logic [DATA_W-1:0]    data_d [NUM_LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Next array contents: a write installs a line, a clear wipes every valid bit and wins over the write.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
        if (clear) begin
            valid_d = '0;
        end
    end

    // Valid bits are the only reset state of the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless without a valid bit, so they are never reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/cache_dm.sv
// rtl/cache_dm.sv - direct-mapped write-through no-write-allocate cache with hit/miss counters
module cache_dm
    import system_widths_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_LINES = DEF_NUM_LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_req_valid,
    output logic              cache_req_ready,
    input  logic              cache_req_we,
    input  logic [ADDR_W-1:0] cache_req_addr,
    input  logic [DATA_W-1:0] cache_req_write,
    output logic              cache_resp_valid,
    output logic [DATA_W-1:0] cache_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_write,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              flush,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    cache_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;
    logic              fill_kill_q, fill_kill_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic              arr_wr_en;
    logic [IDX_W-1:0]  arr_wr_idx;
    logic [TAG_W-1:0]  arr_wr_tag;
    logic [DATA_W-1:0] arr_wr_data;

    logic              accept;
    logic              tag_match;

    // The array is only looked up in IDLE, so it is always addressed by the incoming request.
    cache_dm_array #(
        .DATA_W    (DATA_W),
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .rd_idx   (cache_req_addr[IDX_W-1:0]),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (arr_wr_en),
        .wr_idx   (arr_wr_idx),
        .wr_tag   (arr_wr_tag),
        .wr_data  (arr_wr_data)
    );

    assign accept     = cache_req_valid && cache_req_ready;
    assign tag_match  = arr_valid && (arr_tag == cache_req_addr[ADDR_W-1:IDX_W]);
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Next-state, datapath capture and all bus outputs of the transaction FSM.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        we_d             = we_q;
        wdata_d          = wdata_q;
        hit_data_d       = hit_data_q;
        fill_kill_d      = fill_kill_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
        cache_req_ready  = (state_q == ST_IDLE) && !reset;
        cache_resp_valid = 1'b0;
        cache_resp_data  = '0;
        mem_req_valid    = 1'b0;
        mem_req_we       = 1'b0;
        mem_req_addr     = addr_q;
        mem_req_write    = '0;
        arr_wr_en        = 1'b0;
        arr_wr_idx       = cache_req_addr[IDX_W-1:0];
        arr_wr_tag       = cache_req_addr[ADDR_W-1:IDX_W];
        arr_wr_data      = cache_req_write;

        // A flush while a fill is outstanding means the returning data may be stale w.r.t. the flush.
        if (flush && (state_q == ST_MEM_REQ || state_q == ST_MEM_WAIT)) begin
            fill_kill_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d      = cache_req_addr;
                    we_d        = cache_req_we;
                    wdata_d     = cache_req_write;
                    fill_kill_d = 1'b0;
                    if (cache_req_we) begin
                        arr_wr_en = tag_match;
                        state_d   = ST_MEM_REQ;
                    end else if (tag_match && !flush) begin
                        hit_data_d  = arr_data;
                        hit_count_d = sat_inc(hit_count_q);
                        state_d     = ST_RESP;
                    end else begin
                        miss_count_d = sat_inc(miss_count_q);
                        state_d      = ST_MEM_REQ;
                    end
                end
            end
            ST_RESP: begin
                cache_resp_valid = 1'b1;
                cache_resp_data  = hit_data_q;
                state_d          = ST_IDLE;
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = we_q;
                mem_req_write = we_q ? wdata_q : '0;
                if (mem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    cache_resp_valid = 1'b1;
                    cache_resp_data  = we_q ? '0 : mem_resp_data;
                    arr_wr_en        = !we_q && !fill_kill_q && !flush;
                    arr_wr_idx       = addr_q[IDX_W-1:0];
                    arr_wr_tag       = addr_q[ADDR_W-1:IDX_W];
                    arr_wr_data      = mem_resp_data;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            hit_data_q   <= '0;
            fill_kill_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            hit_data_q   <= hit_data_d;
            fill_kill_q  <= fill_kill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_cache_dm.sv
// tb/tb_cache_dm.sv - self-checking bench for cache_dm against a line-level cache model
module tb_cache_dm;

    logic        clk;
    logic        reset;
    logic        cache_req_valid;
    logic        cache_req_ready;
    logic        cache_req_we;
    logic [15:0] cache_req_addr;
    logic [31:0] cache_req_write;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [15:0] mem_req_addr;
    logic [31:0] mem_req_write;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    cache_dm #(.ADDR_W(16), .DATA_W(32), .NUM_LINES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .cache_req_valid  (cache_req_valid),
        .cache_req_ready  (cache_req_ready),
        .cache_req_we     (cache_req_we),
        .cache_req_addr   (cache_req_addr),
        .cache_req_write  (cache_req_write),
        .cache_resp_valid (cache_resp_valid),
        .cache_resp_data  (cache_resp_data),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_req_write    (mem_req_write),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .flush            (flush),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 1'b0;

    // Model: per-line valid/tag/data, the statistics, and the memory request the cache must be issuing.
    bit          m_valid [16];
    logic [11:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_hit;
    logic [31:0] m_miss;
    logic        exp_mem_we;
    logic [15:0] exp_mem_addr;
    logic [31:0] exp_mem_write;
    logic [31:0] last_resp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Every-cycle checks of outputs that the model fully determines.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!cache_resp_valid) check("resp_data_zero_when_idle", cache_resp_data, 32'h0);
            check("hit_count", hit_count, m_hit);
            check("miss_count", miss_count, m_miss);
            if (mem_req_valid) begin
                check("mem_req_we", {31'h0, mem_req_we}, {31'h0, exp_mem_we});
                check("mem_req_addr", {16'h0, mem_req_addr}, {16'h0, exp_mem_addr});
                check("mem_req_write", mem_req_write, exp_mem_write);
            end
        end
    end

    task automatic do_reset();
        chk_en          = 1'b0;
        reset           = 1'b1;
        cache_req_valid = 1'b0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_data   = '0;
        flush           = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_in_reset", {31'h0, cache_req_ready}, 32'h0);
        check("resp_valid_in_reset", {31'h0, cache_resp_valid}, 32'h0);
        check("mem_req_valid_in_reset", {31'h0, mem_req_valid}, 32'h0);
        check("resp_data_in_reset", cache_resp_data, 32'h0);
        check("hit_count_in_reset", hit_count, 32'h0);
        check("miss_count_in_reset", miss_count, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        model_clear();
        @(negedge clk);
        check("ready_after_reset", {31'h0, cache_req_ready}, 32'h1);
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    // One complete MIU transaction; memory stalls `stall` cycles, answers `lat` cycles after handshake.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int stall, input int lat,
                          input bit flush_acc, input bit flush_wait);
        int          idx;
        logic [11:0] tag;
        bit          hit;
        bit          killed;
        idx = int'(addr[3:0]);
        tag = addr[15:4];
        cache_req_valid = 1'b1;
        cache_req_we    = we;
        cache_req_addr  = addr;
        cache_req_write = wdata;
        flush           = flush_acc;
        @(negedge clk);
        check("req_ready_idle", {31'h0, cache_req_ready}, 32'h1);
        @(posedge clk); #1;
        cache_req_valid = 1'b0;
        flush           = 1'b0;
        hit = !we && m_valid[idx] && (m_tag[idx] == tag) && !flush_acc;
        if (we && m_valid[idx] && (m_tag[idx] == tag)) m_data[idx] = wdata;
        if (flush_acc) model_clear();
        if (!we) begin
            if (hit) m_hit = m_hit + 1;
            else     m_miss = m_miss + 1;
        end
        exp_mem_we    = we;
        exp_mem_addr  = addr;
        exp_mem_write = we ? wdata : 32'h0;
        if (hit) begin
            @(negedge clk);
            check("hit_resp_valid", {31'h0, cache_resp_valid}, 32'h1);
            check("hit_resp_data", cache_resp_data, m_data[idx]);
            check("hit_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
            last_resp = cache_resp_data;
            @(posedge clk); #1;
        end else begin
            killed = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
                check("stall_mem_req_addr", {16'h0, mem_req_addr}, {16'h0, addr});
                check("stall_req_ready", {31'h0, cache_req_ready}, 32'h0);
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            check("mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int i = 0; i < lat; i++) begin
                if (flush_wait && i == 0) begin
                    flush  = 1'b1;
                    killed = 1'b1;
                    model_clear();
                end
                @(negedge clk);
                check("wait_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
                check("wait_no_resp", {31'h0, cache_resp_valid}, 32'h0);
                @(posedge clk); #1;
                flush = 1'b0;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdata;
            @(negedge clk);
            check("mem_resp_valid", {31'h0, cache_resp_valid}, 32'h1);
            check("mem_resp_data", cache_resp_data, we ? 32'h0 : rdata);
            last_resp = cache_resp_data;
            if (!we && !killed) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = rdata;
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        @(negedge clk);
        check("resp_single_cycle", {31'h0, cache_resp_valid}, 32'h0);
        check("ready_back_idle", {31'h0, cache_req_ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset           = 1'b1;
        cache_req_valid = 1'b0;
        cache_req_we    = 1'b0;
        cache_req_addr  = '0;
        cache_req_write = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_data   = '0;
        flush           = 1'b0;
        m_hit           = 0;
        m_miss          = 0;
        last_resp       = 0;
        exp_mem_we      = 0;
        exp_mem_addr    = 0;
        exp_mem_write   = 0;

        // Cold miss then hit
        do_reset();
        do_req(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 3, 1'b0, 1'b0);
        check("lit_miss_resp", last_resp, 32'hDEADBEEF);
        check("lit_miss_count_1", miss_count, 32'd1);
        do_req(1'b0, 16'h0010, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        check("lit_hit_resp", last_resp, 32'hDEADBEEF);
        check("lit_hit_count_1", hit_count, 32'd1);

        // Conflict eviction on index 3
        do_reset();
        do_req(1'b0, 16'h0003, 32'h0, 32'h33330003, 0, 1, 1'b0, 1'b0);
        do_req(1'b0, 16'h0013, 32'h0, 32'h13130013, 0, 2, 1'b0, 1'b0);
        do_req(1'b0, 16'h0003, 32'h0, 32'h33330003, 0, 1, 1'b0, 1'b0);
        check("lit_miss_count_3", miss_count, 32'd3);
        check("lit_hit_count_0", hit_count, 32'd0);

        // Write-through hit updates the line
        do_reset();
        do_req(1'b0, 16'h0010, 32'h0, 32'hCAFE0010, 0, 1, 1'b0, 1'b0);
        do_req(1'b1, 16'h0010, 32'h12345678, 32'hFFFFFFFF, 0, 2, 1'b0, 1'b0);
        check("lit_write_resp_zero", last_resp, 32'h0);
        do_req(1'b0, 16'h0010, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        check("lit_hit_after_write", last_resp, 32'h12345678);

        // Memory back-pressure
        do_req(1'b0, 16'h0025, 32'h0, 32'h25252525, 5, 1, 1'b0, 1'b0);
        do_req(1'b0, 16'h0025, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);

        // Flush during fill suppresses install; response still delivered
        do_req(1'b0, 16'h0020, 32'h0, 32'h20202020, 0, 3, 1'b0, 1'b1);
        check("lit_flush_wait_resp", last_resp, 32'h20202020);
        do_req(1'b0, 16'h0020, 32'h0, 32'h20202021, 0, 1, 1'b0, 1'b0);

        // Flush coincident with accept forces a miss
        do_req(1'b0, 16'h0020, 32'h0, 32'h20202022, 0, 1, 1'b1, 1'b0);
        do_req(1'b0, 16'h0020, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        check("lit_flush_acc_hit", last_resp, 32'h20202022);

        // Write miss does not allocate
        do_req(1'b1, 16'h0044, 32'hAAAA5555, 32'h0, 1, 1, 1'b0, 1'b0);
        do_req(1'b0, 16'h0044, 32'h0, 32'h0BAD0044, 0, 1, 1'b0, 1'b0);

        // Stray memory responses in IDLE are ignored
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h5A5A5A5A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_stray_resp", {31'h0, cache_resp_valid}, 32'h0);
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset while waiting on memory abandons the transaction
        cache_req_valid = 1'b1;
        cache_req_we    = 1'b0;
        cache_req_addr  = 16'h0030;
        @(posedge clk); #1;
        cache_req_valid = 1'b0;
        m_miss          = m_miss + 1;
        exp_mem_we      = 1'b0;
        exp_mem_addr    = 16'h0030;
        exp_mem_write   = 32'h0;
        mem_req_ready   = 1'b1;
        @(posedge clk); #1;
        mem_req_ready   = 1'b0;
        chk_en          = 1'b0;
        reset           = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid  = 1'b1;
        mem_resp_data   = 32'h30303030;
        @(negedge clk);
        check("rst_wait_no_resp", {31'h0, cache_resp_valid}, 32'h0);
        check("rst_wait_ready_low", {31'h0, cache_req_ready}, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        model_clear();
        @(negedge clk);
        check("rst_late_resp_ignored", {31'h0, cache_resp_valid}, 32'h0);
        check("rst_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        chk_en         = 1'b1;
        @(negedge clk);
        check("lit_rst_hit_count", hit_count, 32'h0);
        check("lit_rst_miss_count", miss_count, 32'h0);
        @(posedge clk); #1;
        do_req(1'b0, 16'h0030, 32'h0, 32'h31313131, 0, 1, 1'b0, 1'b0);

        chk_en = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
